// File: rtl/i2c_master_fsm.sv
// ---------------------------------------------------------------------------
// i2c_master_fsm -- control FSM for a byte-oriented I2C master.
//
// Sequences START, address byte, address ACK, data write/read bytes with their
// ACK slots, and the two-phase STOP. The FSM drives the datapath controls; the
// datapath owns the shift registers and the actual SDA/SCL pins.
//
// Parameters
//   DATA_SIZE : data byte width (bit index spans DATA_SIZE bits, 3-bit port)
//   ADDR_SIZE : address byte width; bit 0 is R/W (1 = read)
//
// Ports
//   i2c_core_clk_i    : core clock, all logic on its rising edge
//   reset_i           : synchronous, active-high reset
//   enable_i          : transaction request (level)
//   addr_i            : slave address + R/W, sampled in IDLE
//   i2c_sda_i         : SDA line input (ACK/NACK sampling)
//   i2c_scl_i         : SCL line input (clock stretching only)
//   tx_empty_i        : TX FIFO empty
//   rx_full_i         : RX FIFO full
//   tx_rd_en_o        : TX FIFO pop
//   rx_wr_en_o        : RX FIFO push
//   count_bit_o       : bit index to the datapath
//   sda_low_en_o, sda_high_en_o, write_addr_en_o, write_data_en_o,
//   receive_data_en_o : datapath controls, exactly one high per cycle
//   i2c_scl_en_o      : SCL toggling enable
//   busy_o            : not in IDLE
//   done_o            : one-cycle pulse in the last STOP cycle
//   nack_o            : slave NACK seen, sticky until next START
//
// Build option
//   I2C_CLOCK_STRETCH_EN : when defined, a low i2c_scl_i in any SCL-enabled
//                          state freezes state and bit index and suppresses
//                          FIFO strobes. When undefined i2c_scl_i is ignored.
// ---------------------------------------------------------------------------
module i2c_master_fsm #(
   parameter int unsigned DATA_SIZE = 8,
   parameter int unsigned ADDR_SIZE = 8
) (
   input  logic                 i2c_core_clk_i,
   input  logic                 reset_i,
   input  logic                 enable_i,
   input  logic [ADDR_SIZE-1:0] addr_i,
   input  logic                 i2c_sda_i,
   input  logic                 i2c_scl_i,
   input  logic                 tx_empty_i,
   input  logic                 rx_full_i,
   output logic                 tx_rd_en_o,
   output logic                 rx_wr_en_o,
   output logic [2:0]           count_bit_o,
   output logic                 sda_low_en_o,
   output logic                 sda_high_en_o,
   output logic                 write_addr_en_o,
   output logic                 write_data_en_o,
   output logic                 receive_data_en_o,
   output logic                 i2c_scl_en_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 nack_o
);

   localparam logic [2:0] BitTop = 3'(DATA_SIZE - 1);

   typedef enum logic [3:0] {
      StIdle, StStart, StAddr, StAddrAck, StWriteData, StWriteAck,
      StReadData, StReadAck, StStop1, StStop2
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] count_q, count_d;
   logic       rw_q, rw_d;
   logic       nack_q, nack_d;
   logic       scl_active;
   logic       stall;

   // Only the R/W bit steers the FSM; the address itself goes out via the datapath.
   logic unused_addr;
   assign unused_addr = ^addr_i[ADDR_SIZE-1:1];

   assign scl_active = state_q inside {StAddr, StAddrAck, StWriteData, StWriteAck,
                                       StReadData, StReadAck};

`ifdef I2C_CLOCK_STRETCH_EN
   assign stall = scl_active & ~i2c_scl_i;
`else
   logic unused_scl;
   assign unused_scl = i2c_scl_i;
   assign stall      = 1'b0;
`endif

   always_ff @(posedge i2c_core_clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         count_q <= BitTop;
         rw_q    <= 1'b0;
         nack_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rw_q    <= rw_d;
         nack_q  <= nack_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      count_d           = count_q;
      rw_d              = rw_q;
      nack_d            = nack_q;
      tx_rd_en_o        = 1'b0;
      rx_wr_en_o        = 1'b0;
      sda_low_en_o      = 1'b0;
      sda_high_en_o     = 1'b0;
      write_addr_en_o   = 1'b0;
      write_data_en_o   = 1'b0;
      receive_data_en_o = 1'b0;
      done_o            = 1'b0;

      case (state_q)
         StIdle: begin
            sda_high_en_o = 1'b1;
            if (enable_i) begin
               state_d = StStart;
               rw_d    = addr_i[0];
               nack_d  = 1'b0;
               count_d = BitTop;
            end
         end
         StStart: begin
            sda_low_en_o = 1'b1;
            state_d      = StAddr;
            count_d      = BitTop;
         end
         StAddr, StWriteData, StReadData: begin
            write_addr_en_o   = (state_q == StAddr);
            write_data_en_o   = (state_q == StWriteData);
            receive_data_en_o = (state_q == StReadData);
            if (!stall) begin
               if (count_q == 3'd0) begin
                  count_d = BitTop;
                  case (state_q)
                     StAddr:      state_d = StAddrAck;
                     StWriteData: state_d = StWriteAck;
                     default:     state_d = StReadAck;
                  endcase
               end else begin
                  count_d = count_q - 3'd1;
               end
            end
         end
         StAddrAck, StWriteAck: begin
            sda_high_en_o = 1'b1;
            if (!stall) begin
               if (i2c_sda_i) begin
                  nack_d  = 1'b1;
                  state_d = StStop1;
               end else if (state_q == StAddrAck && rw_q) begin
                  state_d = StReadData;
               end else if (!tx_empty_i) begin
                  // Pop now so the byte is on the datapath for the first data bit.
                  tx_rd_en_o = 1'b1;
                  state_d    = StWriteData;
               end else begin
                  state_d = StStop1;
               end
            end
         end
         StReadAck: begin
            // Master ACKs only if it wants more and the byte just read has a home.
            if (enable_i && !rx_full_i) sda_low_en_o = 1'b1;
            else                         sda_high_en_o = 1'b1;
            if (!stall) begin
               rx_wr_en_o = !rx_full_i;
               state_d    = (enable_i && !rx_full_i) ? StReadData : StStop1;
            end
         end
         StStop1: begin
            sda_low_en_o = 1'b1;
            state_d      = StStop2;
         end
         StStop2: begin
            sda_high_en_o = 1'b1;
            done_o        = 1'b1;
            state_d       = StIdle;
         end
         default: begin
            sda_high_en_o = 1'b1;
            state_d       = StIdle;
         end
      endcase
   end

   assign i2c_scl_en_o = scl_active;
   assign busy_o       = (state_q != StIdle);
   assign count_bit_o  = count_q;
   assign nack_o       = nack_q;

endmodule
